// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pin arbiter.
// Bus-enable encodings and the transaction state machine states.
package uio_arb_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] OE_DRIVE   = 8'hFF;
    localparam logic [BYTE_W-1:0] OE_RELEASE = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_TURN,
        S_SAMPLE,
        S_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NREQ level requests.
// The search starts just after the last winner; the pointer moves only on update.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            update,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IW'(NREQ - 1);
        end else if (update && any) begin
            ptr <= grant_idx;
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any         = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the bidirectional uio pins between NREQ single-byte requesters.
// Every output is registered from the next-state decode so pads never glitch.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int HOLD = 2,
    parameter int TURN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [BYTE_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [BYTE_W-1:0]      rd_data,
    output logic                   busy,
    input  logic [BYTE_W-1:0]      uio_in,
    output logic [BYTE_W-1:0]      uio_out,
    output logic [BYTE_W-1:0]      uio_oe
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = 8;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic [NREQ-1:0]   win_oh;
    logic [NREQ-1:0]   win_oh_nx;
    logic [BYTE_W-1:0] win_data;
    logic [BYTE_W-1:0] win_data_nx;

    logic [NREQ-1:0]   gnt_nx;
    logic [BYTE_W-1:0] rd_nx;
    logic [BYTE_W-1:0] out_nx;
    logic [BYTE_W-1:0] oe_nx;
    logic              busy_nx;

    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic              start;
    logic              sel_wr;
    logic [BYTE_W-1:0] sel_data;

    assign start    = (state == S_IDLE) && ena && arb_any;
    assign sel_wr   = req_wr[arb_idx];
    assign sel_data = req_wdata[arb_idx*BYTE_W +: BYTE_W];

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .update    (start),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            win_oh   <= '0;
            win_data <= '0;
            gnt      <= '0;
            rd_data  <= '0;
            busy     <= 1'b0;
            uio_out  <= '0;
            uio_oe   <= OE_RELEASE;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            win_oh   <= win_oh_nx;
            win_data <= win_data_nx;
            gnt      <= gnt_nx;
            rd_data  <= rd_nx;
            busy     <= busy_nx;
            uio_out  <= out_nx;
            uio_oe   <= oe_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        win_oh_nx   = win_oh;
        win_data_nx = win_data;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    win_oh_nx   = arb_grant;
                    win_data_nx = sel_data;
                    cnt_nx      = '0;
                    if (sel_wr) begin
                        state_nx = S_DRIVE;
                    end else if (TURN == 0) begin
                        state_nx = S_SAMPLE;
                    end else begin
                        state_nx = S_TURN;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt == CW'(HOLD - 1)) begin
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_TURN: begin
                if (cnt == CW'(TURN - 1)) begin
                    state_nx = S_SAMPLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_SAMPLE: state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs follow the state being entered, so they line up with it.
    always_comb begin
        oe_nx   = OE_RELEASE;
        out_nx  = '0;
        gnt_nx  = '0;
        busy_nx = (state_nx != S_IDLE);
        rd_nx   = rd_data;
        if (state_nx == S_DRIVE) begin
            oe_nx  = OE_DRIVE;
            out_nx = win_data_nx;
        end
        if (state_nx == S_DONE) begin
            gnt_nx = win_oh_nx;
        end
        if (state == S_SAMPLE) begin
            rd_nx = uio_in;
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed ops with a grant scoreboard.
// A negedge monitor pops expected grants and tracks the read-data model.
module tb_uio_bus_arbiter;
    import uio_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int HOLD = 2;
    localparam int TURN = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ena = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_wr = '0;
    logic [8*NREQ-1:0] req_wdata = '0;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        rd_data;
    logic              busy;
    logic [7:0]        uio_in = 8'h00;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;

    typedef struct {
        int         idx;
        bit         wr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       e_mon;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_rd = 8'h00;
    logic       rst_q = 1'b1;

    uio_bus_arbiter #(
        .NREQ (NREQ),
        .HOLD (HOLD),
        .TURN (TURN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rd_data   (rd_data),
        .busy      (busy),
        .uio_in    (uio_in),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_q) begin
            exp_rd = 8'h00;
        end else begin
            check("oe_legal",
                  32'(uio_oe == OE_DRIVE || uio_oe == OE_RELEASE), 32'd1);
            if (uio_oe == OE_RELEASE) check("out_released", 32'(uio_out), 32'd0);
            if (gnt != '0) begin
                if (sb.size() == 0) begin
                    check("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    check("gnt_order", 32'(gnt), 32'(1 << e_mon.idx));
                    if (!e_mon.wr) exp_rd = e_mon.data;
                end
            end
            check("rd_data", 32'(rd_data), 32'(exp_rd));
        end
    end

    task automatic push(input int idx, input bit wr, input logic [7:0] d);
        exp_t e;
        e.idx  = idx;
        e.wr   = wr;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_op(input int idx, input bit wr, input logic [7:0] d);
        int lat;
        bit seen;
        @(posedge clk); #1;
        req_wr[idx] = wr;
        if (wr) req_wdata[idx*8 +: 8] = d;
        else uio_in = d;
        req[idx] = 1'b1;
        push(idx, wr, d);
        lat  = wr ? HOLD + 1 : TURN + 2;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= lat - 1) begin
                if (wr) begin
                    check("drv_oe", 32'(uio_oe), 32'(OE_DRIVE));
                    check("drv_out", 32'(uio_out), 32'(d));
                end else begin
                    check("rd_oe", 32'(uio_oe), 32'(OE_RELEASE));
                end
            end
            if (gnt != '0) begin
                seen = 1'b1;
                check("op_latency", 32'(k), 32'(lat));
                req[idx] = 1'b0;
            end
        end
        if (!seen) check("op_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_until(input int n, input bit drop, input int gap);
        int got;
        int prev;
        got  = 0;
        prev = -1;
        for (int k = 0; k < 200 && got < n; k++) begin
            @(negedge clk);
            if (gnt != '0) begin
                if (prev >= 0 && gap > 0) check("gnt_gap", 32'(k - prev), 32'(gap));
                prev = k;
                got++;
                if (got == n) req = '0;
                else if (drop) req = req & ~gnt;
            end
        end
        if (got < n) check("run_timeout", 32'(got), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_oe", 32'(uio_oe), 32'd0);
        check("rst_out", 32'(uio_out), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(0, 1'b1, 8'hA5);
        do_op(1, 1'b0, 8'h3C);

        // both held: order 0,1,0,1, one IDLE between DONE and next DRIVE
        @(posedge clk); #1;
        req_wr    = 2'b11;
        req_wdata = {8'h22, 8'h11};
        req       = 2'b11;
        push(0, 1'b1, 8'h11);
        push(1, 1'b1, 8'h22);
        push(0, 1'b1, 8'h11);
        push(1, 1'b1, 8'h22);
        run_until(4, 1'b0, HOLD + 2);

        @(posedge clk); #1;
        ena            = 1'b0;
        req_wr[0]      = 1'b1;
        req_wdata[7:0] = 8'h5A;
        req[0]         = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("ena_busy", 32'(busy), 32'd0);
            check("ena_gnt", 32'(gnt), 32'd0);
        end
        @(posedge clk); #1;
        ena = 1'b1;
        push(0, 1'b1, 8'h5A);
        @(negedge clk);
        check("ena_c_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("ena_c1_busy", 32'(busy), 32'd1);
        check("ena_c1_oe", 32'(uio_oe), 32'(OE_DRIVE));
        run_until(1, 1'b1, 0);

        @(posedge clk); #1;
        req_wr[0]      = 1'b1;
        req_wdata[7:0] = 8'h77;
        req[0]         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_drv1_oe", 32'(uio_oe), 32'(OE_DRIVE));
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("rst_drv2_oe", 32'(uio_oe), 32'(OE_DRIVE));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_oe", 32'(uio_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        @(posedge clk); #1;
        req_wr    = 2'b11;
        req_wdata = {8'h44, 8'h33};
        req       = 2'b11;
        push(0, 1'b1, 8'h33);
        push(1, 1'b1, 8'h44);
        run_until(2, 1'b1, 0);

        // write then read from requester 0 with req held across
        @(posedge clk); #1;
        req_wr[0]      = 1'b1;
        req_wdata[7:0] = 8'hC3;
        req[0]         = 1'b1;
        push(0, 1'b1, 8'hC3);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        if (!seen) check("mix_wr_timeout", 32'd0, 32'd1);
        req_wr[0] = 1'b0;
        uio_in    = 8'h96;
        push(0, 1'b0, 8'h96);
        lat  = TURN + 3;
        seen = 1'b0;
        for (int k = 1; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (gnt != '0) begin
                seen = 1'b1;
                check("mix_rd_latency", 32'(k), 32'(lat));
            end else begin
                check("mix_oe", 32'(uio_oe), 32'(OE_RELEASE));
            end
        end
        if (!seen) check("mix_rd_timeout", 32'd0, 32'd1);
        req = '0;

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
